// File: rtl/ats21_cmd_issuer.sv
// rtl/ats21_cmd_issuer.sv - dual-channel command FIFOs paired onto a 16-bit two-beat req/ready bus

module ats21_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid,
    input  logic [31:0]   cmd,
    input  logic          pop,
    output logic [31:0]   head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          ovf
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          accept;
    logic          take;

    // Full is judged before the edge, so a same-edge pop never frees room for a push.
    assign full   = (count == CW'(DEPTH));
    assign accept = valid && !full;
    assign take   = pop && (count != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            mem[wr_ptr] <= cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (take) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (valid && full) begin
                ovf <= 1'b1;
            end
            case ({accept, take})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module ats21_cmd_issuer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_valid,
    input  logic [31:0]   a_cmd,
    output logic          a_full,
    output logic [CW-1:0] a_count,
    input  logic          b_valid,
    input  logic [31:0]   b_cmd,
    output logic          b_full,
    output logic [CW-1:0] b_count,
    input  logic          ready,
    output logic          req,
    output logic [15:0]   ctrlA,
    output logic [15:0]   ctrlB,
    output logic          busy,
    output logic [1:0]    err
);
    typedef enum logic [1:0] {IDLE, UPPER, LOWER} state_t;

    state_t      state;
    logic [31:0] a_head;
    logic [31:0] b_head;
    logic [15:0] pa_lo;
    logic [15:0] pb_lo;
    logic        a_ne;
    logic        b_ne;
    logic        accepted;
    logic        load;
    logic [31:0] next_a;
    logic [31:0] next_b;
    logic        a_ovf;
    logic        b_ovf;

    ats21_cmd_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo_a (
        .clk   (clk),
        .reset (reset),
        .valid (a_valid),
        .cmd   (a_cmd),
        .pop   (load && a_ne),
        .head  (a_head),
        .count (a_count),
        .full  (a_full),
        .ovf   (a_ovf)
    );

    ats21_cmd_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo_b (
        .clk   (clk),
        .reset (reset),
        .valid (b_valid),
        .cmd   (b_cmd),
        .pop   (load && b_ne),
        .head  (b_head),
        .count (b_count),
        .full  (b_full),
        .ovf   (b_ovf)
    );

    assign a_ne     = (a_count != '0);
    assign b_ne     = (b_count != '0);
    assign accepted = req && ready;
    // A new pair loads from IDLE regardless of ready, or right as the lower beat is taken.
    assign load     = (a_ne || b_ne) && ((state == IDLE) || (state == LOWER && accepted));
    assign next_a   = a_ne ? a_head : 32'h0;
    assign next_b   = b_ne ? b_head : 32'h0;
    assign busy     = (state != IDLE) || a_ne || b_ne;
    assign err      = {b_ovf, a_ovf};

    // Only the lower halves need holding; upper halves go straight to the bus at load.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            req   <= 1'b0;
            ctrlA <= '0;
            ctrlB <= '0;
            pa_lo <= '0;
            pb_lo <= '0;
        end else if (load) begin
            state <= UPPER;
            req   <= 1'b1;
            ctrlA <= next_a[31:16];
            ctrlB <= next_b[31:16];
            pa_lo <= next_a[15:0];
            pb_lo <= next_b[15:0];
        end else begin
            case (state)
                UPPER: begin
                    if (accepted) begin
                        state <= LOWER;
                        ctrlA <= pa_lo;
                        ctrlB <= pb_lo;
                    end
                end
                LOWER: begin
                    if (accepted) begin
                        state <= IDLE;
                        req   <= 1'b0;
                        ctrlA <= '0;
                        ctrlB <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                    ctrlA <= '0;
                    ctrlB <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ats21_cmd_issuer.sv
// tb/tb_ats21_cmd_issuer.sv - directed self-checking bench for ats21_cmd_issuer

module tb_ats21_cmd_issuer;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          a_valid;
    logic [31:0]   a_cmd;
    logic          a_full;
    logic [CW-1:0] a_count;
    logic          b_valid;
    logic [31:0]   b_cmd;
    logic          b_full;
    logic [CW-1:0] b_count;
    logic          ready;
    logic          req;
    logic [15:0]   ctrlA;
    logic [15:0]   ctrlB;
    logic          busy;
    logic [1:0]    err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] beats [$];
    int          run_len;
    int          req_total;

    ats21_cmd_issuer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .a_valid (a_valid),
        .a_cmd   (a_cmd),
        .a_full  (a_full),
        .a_count (a_count),
        .b_valid (b_valid),
        .b_cmd   (b_cmd),
        .b_full  (b_full),
        .b_count (b_count),
        .ready   (ready),
        .req     (req),
        .ctrlA   (ctrlA),
        .ctrlB   (ctrlB),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; ready = 1'b0;
        a_cmd = 32'h0; b_cmd = 32'h0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Samples once per cycle with ready held by caller; every req=1 sample is a beat taken on the next edge.
    task automatic collect(input int cycles);
        bit started;
        bit ended;
        beats.delete();
        run_len = 0; req_total = 0; started = 1'b0; ended = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (req) begin
                beats.push_back({ctrlA, ctrlB});
                req_total++;
                if (!ended) begin run_len++; started = 1'b1; end
            end else if (started) begin
                ended = 1'b1;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ready = 1'b0; b_valid = 1'b0; b_cmd = 32'h0;
        a_valid = 1'b1; a_cmd = 32'h7777_7777;
        step();
        step();
        reset = 1'b0; a_valid = 1'b0;
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", req); end
        n_checks++; if ({ctrlA, ctrlB} !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 00000000", {ctrlA, ctrlB}); end
        n_checks++; if (a_count !== CW'(0)) begin n_fail++; $display("FAIL reset_a_count: got %0d expected 0", a_count); end
        n_checks++; if (b_count !== CW'(0)) begin n_fail++; $display("FAIL reset_b_count: got %0d expected 0", b_count); end
        n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b expected 00", err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if ({a_full, b_full} !== 2'b00) begin n_fail++; $display("FAIL reset_full: got %b expected 00", {a_full, b_full}); end
    endtask

    task automatic test_single_a();
        do_reset();
        ready = 1'b1; a_valid = 1'b1; a_cmd = 32'h2A40_1234;
        step();
        a_valid = 1'b0;
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL single_push_req: got %b expected 0", req); end
        n_checks++; if (a_count !== CW'(1)) begin n_fail++; $display("FAIL single_push_count: got %0d expected 1", a_count); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_push_busy: got %b expected 1", busy); end
        step();
        n_checks++; if ({req, ctrlA, ctrlB} !== {1'b1, 16'h2A40, 16'h0000}) begin n_fail++; $display("FAIL single_upper: got %b %h %h expected 1 2a40 0000", req, ctrlA, ctrlB); end
        n_checks++; if (a_count !== CW'(0)) begin n_fail++; $display("FAIL single_pop_count: got %0d expected 0", a_count); end
        step();
        n_checks++; if ({req, ctrlA, ctrlB} !== {1'b1, 16'h1234, 16'h0000}) begin n_fail++; $display("FAIL single_lower: got %b %h %h expected 1 1234 0000", req, ctrlA, ctrlB); end
        step();
        n_checks++; if ({req, ctrlA, ctrlB} !== {1'b0, 16'h0000, 16'h0000}) begin n_fail++; $display("FAIL single_idle: got %b %h %h expected 0 0000 0000", req, ctrlA, ctrlB); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_pairing();
        do_reset();
        ready = 1'b1;
        a_valid = 1'b1; a_cmd = 32'h3F00_0000;
        b_valid = 1'b1; b_cmd = 32'hE880_0005;
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        n_checks++; if ({req, ctrlA, ctrlB} !== {1'b1, 16'h3F00, 16'hE880}) begin n_fail++; $display("FAIL pair_upper: got %b %h %h expected 1 3f00 e880", req, ctrlA, ctrlB); end
        step();
        n_checks++; if ({req, ctrlA, ctrlB} !== {1'b1, 16'h0000, 16'h0005}) begin n_fail++; $display("FAIL pair_lower: got %b %h %h expected 1 0000 0005", req, ctrlA, ctrlB); end
        step();
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL pair_end_req: got %b expected 0", req); end
    endtask

    task automatic test_stall();
        do_reset();
        ready = 1'b0;
        a_valid = 1'b1; a_cmd = 32'h1111_2222;
        b_valid = 1'b1; b_cmd = 32'h3333_4444;
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        for (int k = 0; k <= 5; k++) begin
            n_checks++;
            if ({req, ctrlA, ctrlB} !== {1'b1, 16'h1111, 16'h3333}) begin
                n_fail++; $display("FAIL stall_hold_%0d: got %b %h %h expected 1 1111 3333", k, req, ctrlA, ctrlB);
            end
            if (k < 5) step();
        end
        ready = 1'b1;
        step();
        n_checks++; if ({req, ctrlA, ctrlB} !== {1'b1, 16'h2222, 16'h4444}) begin n_fail++; $display("FAIL stall_lower: got %b %h %h expected 1 2222 4444", req, ctrlA, ctrlB); end
        step();
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL stall_end_req: got %b expected 0", req); end
    endtask

    task automatic test_overflow();
        logic [31:0] c   [6];
        logic [31:0] exp [10];
        do_reset();
        ready = 1'b0;
        // Park a channel B pair in UPPER so none of the six A pushes is popped early.
        b_valid = 1'b1; b_cmd = 32'hB0B0_B1B1;
        step();
        b_valid = 1'b0;
        step();
        n_checks++; if ({req, ctrlA, ctrlB} !== {1'b1, 16'h0000, 16'hB0B0}) begin n_fail++; $display("FAIL ovf_parked: got %b %h %h expected 1 0000 b0b0", req, ctrlA, ctrlB); end
        for (int i = 0; i < 6; i++) begin
            c[i] = {16'hA100 + 16'(i), 16'h0010 + 16'(i)};
            a_valid = 1'b1; a_cmd = c[i];
            step();
            n_checks++;
            if (a_count !== CW'((i < 4) ? i + 1 : 4)) begin
                n_fail++; $display("FAIL ovf_count_%0d: got %0d expected %0d", i, a_count, (i < 4) ? i + 1 : 4);
            end
            n_checks++;
            if (err[0] !== ((i >= 4) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL ovf_err_%0d: got %b expected %b", i, err[0], (i >= 4));
            end
        end
        a_valid = 1'b0;
        n_checks++; if (a_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b expected 1", a_full); end
        n_checks++; if (err !== 2'b01) begin n_fail++; $display("FAIL ovf_err_flags: got %b expected 01", err); end
        exp[0] = {16'h0000, 16'hB0B0};
        exp[1] = {16'h0000, 16'hB1B1};
        for (int k = 0; k < 4; k++) begin
            exp[2 + 2 * k] = {c[k][31:16], 16'h0000};
            exp[3 + 2 * k] = {c[k][15:0], 16'h0000};
        end
        ready = 1'b1;
        collect(14);
        n_checks++; if (beats.size() != 10) begin n_fail++; $display("FAIL ovf_beat_count: got %0d expected 10", beats.size()); end
        for (int k = 0; k < 10; k++) begin
            if (k < beats.size()) begin
                n_checks++;
                if (beats[k] !== exp[k]) begin n_fail++; $display("FAIL ovf_beat_%0d: got %h expected %h", k, beats[k], exp[k]); end
            end
        end
        n_checks++; if (err !== 2'b01) begin n_fail++; $display("FAIL ovf_err_sticky: got %b expected 01", err); end
        n_checks++; if ({busy, a_count} !== {1'b0, CW'(0)}) begin n_fail++; $display("FAIL ovf_drained: got busy %b count %0d expected 0 0", busy, a_count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] c   [3];
        c[0] = 32'h1234_5678; c[1] = 32'h9ABC_DEF0; c[2] = 32'h0F0F_F0F0;
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_valid = 1'b1; b_cmd = c[i];
            step();
        end
        b_valid = 1'b0;
        n_checks++; if (b_count !== CW'(2)) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", b_count); end
        ready = 1'b1;
        collect(10);
        n_checks++; if (run_len != 6) begin n_fail++; $display("FAIL b2b_run: got %0d expected 6", run_len); end
        n_checks++; if (req_total != 6) begin n_fail++; $display("FAIL b2b_total: got %0d expected 6", req_total); end
        for (int k = 0; k < 6; k++) begin
            if (k < beats.size()) begin
                n_checks++;
                if (beats[k] !== {16'h0000, (k % 2 == 0) ? c[k / 2][31:16] : c[k / 2][15:0]}) begin
                    n_fail++; $display("FAIL b2b_beat_%0d: got %h expected %h", k, beats[k],
                                       {16'h0000, (k % 2 == 0) ? c[k / 2][31:16] : c[k / 2][15:0]});
                end
            end
        end
    endtask

    task automatic test_reset_mid_pair();
        do_reset();
        ready = 1'b1;
        a_valid = 1'b1; a_cmd = 32'hDEAD_BEEF;
        step();
        a_valid = 1'b0;
        step();
        n_checks++; if ({req, ctrlA} !== {1'b1, 16'hDEAD}) begin n_fail++; $display("FAIL mid_upper: got %b %h expected 1 dead", req, ctrlA); end
        step();
        n_checks++; if ({req, ctrlA} !== {1'b1, 16'hBEEF}) begin n_fail++; $display("FAIL mid_lower_pending: got %b %h expected 1 beef", req, ctrlA); end
        reset = 1'b1;
        a_valid = 1'b1; a_cmd = 32'h5555_5555;
        step();
        reset = 1'b0; a_valid = 1'b0;
        n_checks++; if ({req, ctrlA, ctrlB} !== 33'h0) begin n_fail++; $display("FAIL mid_reset_bus: got %b %h %h expected 0 0000 0000", req, ctrlA, ctrlB); end
        n_checks++; if ({a_count, b_count} !== {CW'(0), CW'(0)}) begin n_fail++; $display("FAIL mid_reset_counts: got %0d %0d expected 0 0", a_count, b_count); end
        n_checks++; if ({err, busy} !== 3'b000) begin n_fail++; $display("FAIL mid_reset_err_busy: got %b %b expected 00 0", err, busy); end
        collect(6);
        n_checks++; if (req_total != 0) begin n_fail++; $display("FAIL mid_no_lower: got %0d beats expected 0", req_total); end
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_pairing();
        test_stall();
        test_overflow();
        test_back_to_back();
        test_reset_mid_pair();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ats21_cmd_issuer.md
# ats21_cmd_issuer

Upstream command issuer for the ats21 alarm/timer block. It buffers 32-bit commands for channel A and channel B in two independent FIFOs. It pairs one command from each channel and sends each pair over the shared 16-bit `ctrlA`/`ctrlB` bus as two beats, upper half first, using the `req`/`ready` handshake. When one channel has no command, its slot in the pair carries a NOP (all zeros, opcode `000`), so the two channels never block each other.

## Interface
Parameters:
- `DEPTH`, 4 — entries per channel FIFO; power of two, minimum 2.
- `CW`, `$clog2(DEPTH+1)` — width of the occupancy counts.

Ports:
- `clk` in 1 — single clock; all logic on its rising edge.
- `reset` in 1 — synchronous, active-high.
- `a_valid` in 1 — push request, channel A.
- `a_cmd` in 32 — channel A command; `[31:29]` opcode, `[28:0]` operands.
- `a_full` out 1 — channel A FIFO full; combinational from `a_count`.
- `a_count` out CW — channel A occupancy.
- `b_valid`, `b_cmd`, `b_full`, `b_count` — same as channel A, for channel B.
- `ready` in 1 — downstream can accept a beat.
- `req` out 1 — beat valid; registered.
- `ctrlA` out 16 — channel A half-word; registered.
- `ctrlB` out 16 — channel B half-word; registered.
- `busy` out 1 — high when the FSM is not in IDLE or either FIFO is non-empty.
- `err` out 2 — sticky overflow flags; bit 0 = channel A, bit 1 = channel B.

## Operation
- **Push:** an edge with `x_valid=1` and `x_full=0` writes `x_cmd` to the tail of that FIFO.
  - An edge with `x_valid=1` and `x_full=1` drops the command and sets `err[x]`.
  - Pushes are checked against `x_full` as it is before the edge. A pop on the same edge does not make room for a push into a full FIFO.
- **Push and pop on the same edge** (FIFO not full): the count does not change and the data order is kept.
- **Pair load:** the pair registers `pA` and `pB` take the FIFO heads.
  - An empty FIFO contributes 32'h0 and is not popped.
  - A non-empty FIFO is popped.
- **FSM states:** IDLE, UPPER, LOWER.
  - IDLE: `req=0`, `ctrlA=ctrlB=0`. If either FIFO is non-empty, load the pair and go to UPPER. The load does not depend on `ready`.
  - UPPER: `req=1`, `ctrlA=pA[31:16]`, `ctrlB=pB[31:16]`. A beat is accepted on an edge with `req && ready`; on acceptance go to LOWER.
  - LOWER: `req=1`, `ctrlA=pA[15:0]`, `ctrlB=pB[15:0]`. On acceptance, if either FIFO is non-empty, load the next pair and go to UPPER (back-to-back transfer). Otherwise go to IDLE.
- **Stall:** while `req=1` and `ready=0`, `req`, `ctrlA` and `ctrlB` hold their values exactly.
- **Ordering:** commands within a channel are issued in push order. The block never issues an upper half without the lower half that follows it.
- **No interpretation:** the block does not decode opcodes. Commands pass through bit-exact.
- **Reset:**
  - Clears both FIFOs and sets both counts to 0.
  - Sets the FSM to IDLE, with `req=0`, `ctrlA=ctrlB=0`, `err=0` and `busy=0`.
  - Any pair in flight is discarded, including one stopped between the upper and lower beats.
  - A push on the same edge as reset is ignored.
- **Counter widths:** FIFO pointers are `$clog2(DEPTH)` bits and wrap naturally. `x_full` is `x_count==DEPTH`.

## Timing
- **Latency:** a command pushed on edge N into an idle block with empty FIFOs:
  - is popped on edge N+1;
  - `req=1` with its upper half is visible after edge N+1;
  - with `ready` held high, the upper beat is accepted at N+2 and the lower beat at N+3.
- **Throughput:** with `ready` held high, one pair every 2 cycles, with no IDLE gap.
- **`a_count`/`b_count`** update on the edge after the push or pop.
- **`busy`** is combinational from the state and the counts.

## Test plan
- **Single command, channel A:**
  - Stimulus: after reset, push `a_cmd`=32'h2A40_1234 with `ready=1`.
  - Required response: `req` high for exactly 2 cycles.
  - Beat 1: `ctrlA`=16'h2A40, `ctrlB`=16'h0000.
  - Beat 2: `ctrlA`=16'h1234, `ctrlB`=16'h0000.
  - Afterwards: IDLE, `busy=0`.
- **Pairing:**
  - Stimulus: push A=32'h3F00_0000 and B=32'hE880_0005 on the same edge.
  - Required response: beat 1 (16'h3F00, 16'hE880), then beat 2 (16'h0000, 16'h0005).
- **Stall:**
  - Stimulus: hold `ready=0` for 5 cycles during the UPPER beat, then raise it.
  - Required response: the upper values stay constant on `ctrlA`/`ctrlB` for all 5 cycles, and the lower beat follows only after acceptance.
- **Overflow:**
  - Stimulus: with `DEPTH=4` and `ready=0`, push 6 commands to channel A.
  - Required response: `a_count` saturates at 4 and `err[0]=1`.
  - After releasing `ready`: the first 4 commands are issued in order. The 5th and 6th are not issued. The first command is popped into the pair at load, before the 5th and 6th pushes, so pin the exact push edges in the bench.
- **Back-to-back:**
  - Stimulus: 3 commands queued in channel B, `ready=1`.
  - Required response: `req` stays high for 6 consecutive cycles, and channel A carries zeros.
- **Reset mid-pair:**
  - Stimulus: assert `reset` right after the upper beat is accepted.
  - Required response: next cycle `req=0`, `ctrlA=ctrlB=0`, counts 0, `err=0`, and no lower beat is ever issued.
